// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front end: default sizes, state encoding and
// the index bit-reversal helper used by the loader and the output reorder stage.
package fft_pkg;

  localparam int unsigned WORD_LENGTH_DEF = 8;
  localparam int unsigned N_POINTS_DEF    = 16;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  // Address width for an N-point frame; a 2-point frame still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Reverse the low `width` bits of idx (width <= 16); upper result bits are zero.
  function automatic logic [15:0] bitrev(input logic [15:0] idx, input int unsigned width);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    t = idx;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < width) begin
        r = {r[14:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Combinational frame-slot address generator: passes the index straight through
// or bit-reverses it for a decimation-in-time butterfly core.
module fft_bitrev_addr
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter bit          ENABLE = 1'b1
) (
  input  logic [WIDTH-1:0] i_idx,
  output logic [WIDTH-1:0] o_idx
);

  logic [WIDTH-1:0] w_rev;

  always_comb begin
    w_rev = WIDTH'(bitrev(16'(i_idx), WIDTH));
    o_idx = ENABLE ? w_rev : i_idx;
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Pops one frame of samples from the sample FIFO into a register bank, pulses
// fft_start, then holds the frame until the butterfly core reports fft_done.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int unsigned N_POINTS    = N_POINTS_DEF,
  parameter bit          BIT_REVERSE = 1'b1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [WORD_LENGTH-1:0]          i_fifo_data,
  input  logic                            i_fifo_empty,
  output logic                            o_fifo_r_en,
  input  logic                            i_fft_done,
  output logic                            o_fft_start,
  output logic                            o_busy,
  output logic [N_POINTS*WORD_LENGTH-1:0] o_frame,
  output logic [7:0]                      o_frame_cnt
);

  localparam int unsigned      IDX_W    = idx_width(N_POINTS);
  localparam int unsigned      CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_POINTS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_POINTS - 1);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [CNT_W-1:0]       r_rd_cnt;
  logic [CNT_W-1:0]       r_wr_cnt;
  logic                   r_rd_vld;
  logic [WORD_LENGTH-1:0] r_bank [N_POINTS];
  logic [7:0]             r_frame_cnt;
  logic                   w_accept;
  logic                   w_last_capture;
  logic [IDX_W-1:0]       w_wr_slot;

  fft_bitrev_addr #(
    .WIDTH  (IDX_W),
    .ENABLE (BIT_REVERSE)
  ) u_addr (
    .i_idx (r_wr_cnt[IDX_W-1:0]),
    .o_idx (w_wr_slot)
  );

  assign w_accept       = o_fifo_r_en && !i_fifo_empty;
  assign w_last_capture = r_rd_vld && (r_wr_cnt == LAST_CNT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL:      if (w_last_capture) w_state_next = START;
      START:     w_state_next = WAIT_DONE;
      WAIT_DONE: if (i_fft_done) w_state_next = FILL;
      default:   w_state_next = FILL;
    endcase
  end

  // Reads are masked during reset so no sample is popped and then discarded.
  always_comb begin
    o_fifo_r_en = 1'b0;
    o_fft_start = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      FILL: begin
        o_busy      = 1'b0;
        o_fifo_r_en = !i_rst && (r_rd_cnt < N_CNT) && !i_fifo_empty;
      end
      START:   o_fft_start = 1'b1;
      default: ;
    endcase
  end

  // FIFO data arrives one cycle after the accept, so capture trails reads by rd_vld.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_rd_vld    <= 1'b0;
      r_frame_cnt <= '0;
      for (int i = 0; i < int'(N_POINTS); i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      r_rd_vld <= w_accept;
      if (r_state == START) begin
        r_rd_cnt    <= '0;
        r_wr_cnt    <= '0;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else begin
        if (w_accept) begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
        if (r_rd_vld) begin
          r_bank[w_wr_slot] <= i_fifo_data;
          r_wr_cnt          <= r_wr_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < int'(N_POINTS); g++) begin : g_frame
    assign o_frame[g*WORD_LENGTH +: WORD_LENGTH] = r_bank[g];
  end

  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench: a bit-reversing and a natural-order loader share one FIFO
// model; a scoreboard of expected frames is compared on every fft_start.
module tb_fft_frame_loader;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   fifo_data = '0;
  logic         fifo_empty;
  logic         fft_done;
  logic         r_en_a, r_en_b, start_a, start_b, busy_a, busy_b;
  logic [127:0] frame_a, frame_b;
  logic [7:0]   cnt_a, cnt_b;

  always #5 clk = ~clk;

  fft_frame_loader #(.WORD_LENGTH(8), .N_POINTS(16), .BIT_REVERSE(1'b1)) u_dut_rev (
    .i_clk(clk), .i_rst(rst), .i_fifo_data(fifo_data), .i_fifo_empty(fifo_empty),
    .o_fifo_r_en(r_en_a), .i_fft_done(fft_done), .o_fft_start(start_a), .o_busy(busy_a),
    .o_frame(frame_a), .o_frame_cnt(cnt_a)
  );

  fft_frame_loader #(.WORD_LENGTH(8), .N_POINTS(16), .BIT_REVERSE(1'b0)) u_dut_nrm (
    .i_clk(clk), .i_rst(rst), .i_fifo_data(fifo_data), .i_fifo_empty(fifo_empty),
    .o_fifo_r_en(r_en_b), .i_fft_done(fft_done), .o_fft_start(start_b), .o_busy(busy_b),
    .o_frame(frame_b), .o_frame_cnt(cnt_b)
  );

  // FIFO model with a registered read port, popped by the bit-reversing instance.
  logic [7:0] mem [0:8191];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  int  n_accept = 0;
  int  cyc = 0;
  bit  force_empty = 1'b0;

  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (r_en_a && !fifo_empty) begin
      fifo_data <= mem[rd_ptr[12:0]];
      rd_ptr    <= rd_ptr + 1;
      n_accept  <= n_accept + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  typedef struct {
    logic [127:0] rev;
    logic [127:0] nrm;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    if (start_a) begin
      exp_t e;
      n_starts++;
      check("start_pair", start_b, 1'b1);
      if (exp_q.size() == 0) begin
        fail_now("sb_underflow");
      end else begin
        e = exp_q.pop_front();
        check("frame_rev", frame_a, e.rev);
        check("frame_nrm", frame_b, e.nrm);
      end
    end
  end

  function automatic logic [3:0] tb_rev(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  task automatic load_frame(input logic [127:0] s);
    exp_t e;
    e.nrm = s;
    e.rev = '0;
    for (int k = 0; k < N; k++) begin
      e.rev[int'(tb_rev(4'(k)))*8 +: 8] = s[k*8 +: 8];
      mem[wr_ptr[12:0]] = s[k*8 +: 8];
      wr_ptr++;
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_start(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (start_a) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now(name);
  endtask

  task automatic wait_accepts(input int base, input int count, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (n_accept - base == count) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_now(name);
  endtask

  // Called on the fft_start negedge: step into WAIT_DONE, then return fft_done.
  task automatic finish_frame();
    @(negedge clk);
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
  endtask

  typedef struct {
    string      name;
    int         frm;
    int         slot;
    bit         rev;
    logic [7:0] exp;
  } slot_vec_t;
  slot_vec_t vecs[8];

  task automatic set_vec(input int i, input string name, input int frm, input int slot,
                         input bit rev, input logic [7:0] exp);
    vecs[i].name = name;
    vecs[i].frm  = frm;
    vecs[i].slot = slot;
    vecs[i].rev  = rev;
    vecs[i].exp  = exp;
  endtask

  task automatic apply_vecs(input int frm);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].frm == frm) begin
        check(vecs[i].name,
              vecs[i].rev ? frame_a[vecs[i].slot*8 +: 8] : frame_b[vecs[i].slot*8 +: 8],
              vecs[i].exp);
      end
    end
  endtask

  initial begin
    logic [127:0] s;
    logic [127:0] snap;
    int acc0, st0, en_cnt, first, last, last_acc, st_cyc, n_st;
    bit saw_en, saw_idle;

    set_vec(0, "f1_slot1",  1, 1,  1'b1, 8'd8);
    set_vec(1, "f1_slot8",  1, 8,  1'b1, 8'd1);
    set_vec(2, "f1_slot3",  1, 3,  1'b1, 8'd12);
    set_vec(3, "f1_slot15", 1, 15, 1'b1, 8'd15);
    set_vec(4, "f2_slot0",  2, 0,  1'b0, 8'h80);
    set_vec(5, "f2_slot1",  2, 1,  1'b0, 8'h7F);
    set_vec(6, "f2_slot2",  2, 2,  1'b0, 8'hFF);
    set_vec(7, "f2_slot3",  2, 3,  1'b0, 8'h00);

    rst = 1'b1;
    fft_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_held_r_en", r_en_a, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_r_en", r_en_a, 1'b0);
    check("rst_start", start_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_frame", frame_a, '0);
    check("rst_cnt", cnt_a, 8'd0);

    // Frame 1: ramp 0..15, FIFO never empty once loaded.
    for (int k = 0; k < N; k++) s[k*8 +: 8] = 8'(k);
    acc0 = n_accept;
    load_frame(s);
    #1;
    en_cnt = 0; first = -1; last = -1; last_acc = -1; st_cyc = -1; n_st = 0;
    for (int i = 0; i < 40; i++) begin
      if (r_en_a) begin
        en_cnt++;
        if (first < 0) first = i;
        last = i;
        last_acc = cyc;
      end
      if (start_a) begin
        n_st++;
        if (st_cyc < 0) st_cyc = cyc;
      end
      @(negedge clk);
    end
    check("f1_r_en_cycles", 128'(en_cnt), 128'd16);
    check("f1_r_en_contig", 128'(last - first + 1), 128'd16);
    check("f1_accepts", 128'(n_accept - acc0), 128'd16);
    check("f1_start_lat", 128'(st_cyc - last_acc), 128'd2);
    check("f1_start_once", 128'(n_st), 128'd1);
    apply_vecs(1);
    check("f1_cnt", cnt_a, 8'd1);
    check("f1_busy", busy_a, 1'b1);
    check("f1_busy_nrm", busy_b, 1'b1);
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;

    // Frame 2: sign extremes stored bit-exact.
    for (int k = 0; k < N; k++) s[k*8 +: 8] = 8'(k * 5 + 1);
    s[7:0] = 8'h80; s[15:8] = 8'h7F; s[23:16] = 8'hFF; s[31:24] = 8'h00;
    load_frame(s);
    wait_start("f2_start");
    apply_vecs(2);
    finish_frame();

    // Frame 3: FIFO empty for 5 cycles after the 6th sample.
    for (int k = 0; k < N; k++) s[k*8 +: 8] = 8'h40 + 8'(k);
    acc0 = n_accept;
    st0 = n_starts;
    load_frame(s);
    wait_accepts(acc0, 6, "f3_six_accepts");
    force_empty = 1'b1;
    #1;
    saw_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (r_en_a) saw_en = 1'b1;
      @(negedge clk);
    end
    check("f3_stall_r_en", saw_en, 1'b0);
    force_empty = 1'b0;
    wait_start("f3_start");
    finish_frame();
    check("f3_accepts", 128'(n_accept - acc0), 128'd16);
    check("f3_one_start", 128'(n_starts - st0), 128'd1);

    // Frame 4: fft_done in FILL and in START must be ignored.
    for (int k = 0; k < N; k++) s[k*8 +: 8] = 8'hA0 + 8'(k);
    load_frame(s);
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    wait_start("f4_start");
    fft_done = 1'b1;
    snap = frame_a;
    @(negedge clk);
    fft_done = 1'b0;
    for (int k = 0; k < N; k++) s[k*8 +: 8] = 8'h10 + 8'(k);
    load_frame(s);
    saw_en = 1'b0;
    saw_idle = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (r_en_a) saw_en = 1'b1;
      if (!busy_a) saw_idle = 1'b1;
    end
    check("f4_hold_r_en", saw_en, 1'b0);
    check("f4_hold_busy", saw_idle, 1'b0);
    check("f4_hold_frame", frame_a, snap);
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    check("f4_first_read", r_en_a, 1'b1);
    check("f4_fill_busy", busy_a, 1'b0);
    wait_start("f5_start");
    finish_frame();

    // Reset after 9 accepts discards the partial frame.
    for (int k = 0; k < N; k++) s[k*8 +: 8] = 8'hC0 + 8'(k);
    acc0 = n_accept;
    load_frame(s);
    wait_accepts(acc0, 9, "rst9_accepts");
    rst = 1'b1;
    #1;
    check("rst9_r_en_now", r_en_a, 1'b0);
    @(negedge clk);
    check("rst9_frame_rev", frame_a, '0);
    check("rst9_frame_nrm", frame_b, '0);
    check("rst9_cnt", cnt_a, 8'd0);
    check("rst9_r_en", r_en_a, 1'b0);
    exp_q.delete();
    wr_ptr = rd_ptr;
    rst = 1'b0;
    st0 = n_starts;
    for (int k = 0; k < N; k++) s[k*8 +: 8] = 8'h55 ^ 8'(k * 3);
    load_frame(s);
    wait_start("rst9_start");
    finish_frame();
    check("rst9_one_start", 128'(n_starts - st0), 128'd1);
    check("rst9_cnt_after", cnt_a, 8'd1);

    // 255 more back-to-back frames take frame_cnt from 1 through 255 to 0.
    for (int k = 0; k < N; k++) s[k*8 +: 8] = 8'(k * 13 + 3);
    load_frame(s);
    for (int f = 0; f < 255; f++) begin
      wait_start("b2b_start");
      if (f == 254) check("b2b_cnt_255", cnt_a, 8'hFF);
      if (f < 254) begin
        for (int k = 0; k < N; k++) s[k*8 +: 8] = 8'((f + 1) * 7 + k * 13 + 3);
        load_frame(s);
      end
      repeat (3) @(negedge clk);
      fft_done = 1'b1;
      @(negedge clk);
      fft_done = 1'b0;
    end
    check("b2b_cnt_wrap", cnt_a, 8'd0);
    check("b2b_cnt_wrap_nrm", cnt_b, 8'd0);
    check("b2b_sb_drained", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Read-side consumer of the sample FIFO. Pops N_POINTS signed samples through the FIFO's r_en/empty handshake and absorbs its 1-cycle registered read latency.
- Writes the samples into a frame register bank, optionally at bit-reversed addresses for the DIT butterfly core.
- Pulses fft_start and holds the frame stable until the core returns fft_done, then refills.

Parameters:
- WORD_LENGTH, 8, sample width in bits (signed two's complement).
- N_POINTS, 16, samples per frame; power of two, at least 2.
- BIT_REVERSE, 1, 1 = sample k stored at bitrev(k); 0 = stored at k.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_data  input  WORD_LENGTH  signed FIFO data_out; valid the cycle after an accepted read.
- fifo_empty  input  1  FIFO empty flag.
- fifo_r_en  output  1  FIFO read request.
- fft_done  input  1  core finished the current frame; sampled only in WAIT_DONE.
- fft_start  output  1  one-cycle pulse: frame is complete and stable.
- busy  output  1  high in every state except FILL.
- frame  output  N_POINTS*WORD_LENGTH  flattened bank; slot i occupies bits [i*WORD_LENGTH +: WORD_LENGTH].
- frame_cnt  output  8  completed frames, wraps 255 to 0.

Behaviour:
- Reset: synchronous, active-high; all state is cleared on the clk edge where rst=1.
  - Outputs after reset: fifo_r_en=0, fft_start=0, busy=0, frame=0, frame_cnt=0.
  - Internal state after reset: state=FILL, rd_cnt=0, wr_cnt=0, rd_vld=0.
  - Reset mid-frame discards partial samples. Reads already popped from the FIFO are lost, with no recovery.
- Counters: IDX_W=$clog2(N_POINTS). rd_cnt and wr_cnt are IDX_W+1 bits wide.
- Read accept is defined as accept = fifo_r_en && !fifo_empty, matching the FIFO's internal read qualification.
- fifo_r_en (combinational) = (state==FILL) && (rd_cnt < N_POINTS) && !fifo_empty. The block never requests beyond N_POINTS per frame.
- Latency pipeline:
  - rd_vld <= accept.
  - When rd_vld=1, fifo_data is written to slot BIT_REVERSE ? bitrev(wr_cnt[IDX_W-1:0]) : wr_cnt[IDX_W-1:0], and wr_cnt increments.
  - Sample latency is one cycle from accept to capture.
- Empty stalls: fifo_empty may toggle at any time. No reads are issued while it is high, and capture resumes without gaps or duplicates.
- States:
  - FILL: reads issued as above. When rd_vld=1 and wr_cnt==N_POINTS-1 (last capture), go to START.
  - START: fft_start=1 for exactly one cycle; frame_cnt increments; rd_cnt and wr_cnt clear; go to WAIT_DONE. No reads are issued.
  - WAIT_DONE: no reads; frame held constant. fft_done=1 returns to FILL on the next edge.
- fft_done outside WAIT_DONE is ignored, including fft_done coincident with fft_start.
- Back-to-back frames: the first read of the next frame can be issued in the first FILL cycle after the fft_done edge.
  - Minimum period = N_POINTS + 3 cycles plus the core's compute time.
- Arithmetic: samples are stored bit-exact with no sign extension or saturation. frame is a pure register output, with no combinational path from inputs.
- Frame contents persist across FILL and are overwritten slot by slot. Consumers read frame only between fft_start and fft_done.

Decomposition:
- Shared package fft_pkg:
  - WORD_LENGTH and N_POINTS defaults.
  - IDX_W derivation.
  - State encoding localparams FILL=2'd0, START=2'd1, WAIT_DONE=2'd2.
  - Function bitrev(idx, width), reused by the output reorder stage.
- One sub-module is natural: fft_bitrev_addr, a parameterised combinational index reverser.
- FSM, counters and register bank stay in fft_frame_loader.

Test Plan:
- Reset then a FIFO preloaded with 0..15 and empty never asserted:
  - fifo_r_en high for exactly 16 consecutive cycles.
  - fft_start pulses 2 cycles after the 16th accept.
  - With BIT_REVERSE=1: slot 1 = 8, slot 8 = 1, slot 3 = 12, slot 15 = 15.
- BIT_REVERSE=0, samples -128, 127, -1, 0, ... -> slots 0..3 = 8'h80, 8'h7F, 8'hFF, 8'h00 (sign preserved).
- fifo_empty forced high for 5 cycles after sample 6:
  - fifo_r_en low throughout the stall.
  - Final frame matches the ordered input; exactly 16 accepts in total; one fft_start.
- fft_done pulsed during FILL and in the START cycle:
  - Both are ignored.
  - The loader stays in WAIT_DONE with frame unchanged until a later fft_done, then FILL issues the next read on the following cycle.
- rst asserted after 9 accepts:
  - Next cycle: frame=0, fifo_r_en=0 during reset, frame_cnt=0.
  - After release, 16 fresh samples produce one fft_start.
- 256 back-to-back frames with fft_done returned 4 cycles after each fft_start:
  - frame_cnt wraps to 0.
  - The final frame's contents are correct.
